// File: rtl/management_bridge.sv
// Byte-stream host to 16-bit register bus bridge: address phase, write bursts,
// prefetching read bursts with a read-response timeout and sticky status flags.
module management_bridge #(
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        txn_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        underrun,
  output logic        timeout
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR_HI   = 3'd1;
  localparam logic [2:0] ADDR_LO   = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] READ_WAIT = 3'd4;
  localparam logic [2:0] READ_HOLD = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              cmd_read_q, cmd_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        rd_en_d, wr_en_d, tx_valid_d, underrun_d, timeout_d;
  logic [15:0] rd_addr_d, wr_addr_d;
  logic [7:0]  wr_data_d, tx_data_d;

  // 15-bit address space wraps naturally on overflow
  assign addr_inc = addr_q + ADDR_W'(1);

  // Next-state and next-output logic; txn_start overrides everything
  always_comb begin
    state_d    = state_q;
    cmd_read_d = cmd_read_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    underrun_d = underrun;
    timeout_d  = timeout;

    if (txn_start) begin
      state_d    = ADDR_HI;
      tx_valid_d = 1'b0;
      underrun_d = 1'b0;
      timeout_d  = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ADDR_HI: begin
          if (rx_valid) begin
            cmd_read_d = rx_data[7];
            addr_d     = {rx_data[6:0], addr_q[7:0]};
            state_d    = ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (rx_valid) begin
            addr_d = {addr_q[14:8], rx_data};
            if (cmd_read_q) begin
              rd_en_d   = 1'b1;
              rd_addr_d = {1'b0, addr_q[14:8], rx_data};
              cnt_d     = '0;
              state_d   = READ_WAIT;
            end else begin
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {1'b0, addr_q};
            wr_data_d = rx_data;
            addr_d    = addr_inc;
          end
        end
        READ_WAIT: begin
          if (tx_ready && !tx_valid) begin
            underrun_d = 1'b1;
          end
          // A response arriving on the expiry cycle still counts as a response
          if (rd_valid) begin
            tx_data_d  = rd_data;
            tx_valid_d = 1'b1;
            state_d    = READ_HOLD;
          end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
            tx_data_d  = 8'hFF;
            tx_valid_d = 1'b1;
            timeout_d  = 1'b1;
            state_d    = READ_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        READ_HOLD: begin
          if (tx_ready) begin
            if (tx_valid) begin
              tx_valid_d = 1'b0;
              addr_d     = addr_inc;
              rd_en_d    = 1'b1;
              rd_addr_d  = {1'b0, addr_inc};
              cnt_d      = '0;
              state_d    = READ_WAIT;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_read_q <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      underrun   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_read_q <= cmd_read_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      underrun   <= underrun_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_management_bridge.sv
// Directed plus randomized transaction-level checks of management_bridge
// against expected bus traffic computed from address arithmetic.
module tb_management_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        txn_start, rx_valid, tx_ready, rd_valid;
  logic [7:0]  rx_data, rd_data;
  logic        tx_valid, rd_en, wr_en, underrun, timeout;
  logic [7:0]  tx_data, wr_data;
  logic [15:0] rd_addr, wr_addr;

  int checks = 0;
  int failures = 0;

  logic [23:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic        both_seen = 1'b0;
  logic        b15_seen = 1'b0;

  management_bridge #(.RD_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .txn_start(txn_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .underrun(underrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Bus traffic recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (rd_en) rd_q.push_back(rd_addr);
    if (rd_en && wr_en) both_seen = 1'b1;
    if ((rd_en && rd_addr[15]) || (wr_en && wr_addr[15])) b15_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    txn_start = 1'b1;
    cyc();
    txn_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
  endtask

  task automatic respond(input logic [7:0] d);
    rd_valid = 1'b1;
    rd_data  = d;
    cyc();
    rd_valid = 1'b0;
  endtask

  function automatic logic [15:0] wrap(input int unsigned a);
    return 16'(a % 32768);
  endfunction

  initial begin
    logic [14:0] a;
    logic [7:0]  d;
    int          n;
    logic [23:0] exp_w[$];

    rst_n = 1'b0; txn_start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; rd_valid = 1'b0;
    rx_data = 8'h00; rd_data = 8'h00;

    // Reset holds everything at zero regardless of inputs
    rx_valid = 1'b1; rx_data = 8'h9A; tx_ready = 1'b1; rd_valid = 1'b1; txn_start = 1'b1;
    repeat (3) cyc();
    txn_start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; rd_valid = 1'b0;
    chk("reset_outputs", {rd_en, wr_en, tx_valid, underrun, timeout}, 0);
    chk("reset_buses", {rd_addr, wr_addr, wr_data, tx_data}, 0);
    rst_n = 1'b1;
    cyc();

    // Inputs before the first txn_start are ignored
    send(8'h12); send(8'h34); send(8'h56); pulse_ready(); respond(8'h11);
    cyc(); cyc();
    chk("idle_no_writes", wr_q.size(), 0);
    chk("idle_no_reads", rd_q.size(), 0);
    chk("idle_no_status", {tx_valid, underrun}, 0);

    // Directed write burst with one-cycle strobe timing
    start();
    send(8'h12); send(8'h34);
    send(8'hAA);
    chk("wb_wr_en_1", wr_en, 1);
    chk("wb_beat_1", {wr_addr, wr_data}, 24'h1234AA);
    cyc();
    chk("wb_wr_en_pulse", wr_en, 0);
    send(8'hBB);
    chk("wb_beat_2", {wr_en, wr_addr, wr_data}, {1'b1, 24'h1235BB});
    cyc(); cyc();
    chk("wb_write_count", wr_q.size(), 2);
    chk("wb_no_read", rd_q.size(), 0);

    // Randomized write bursts, first one straddling the address wrap
    for (int t = 0; t < 4; t++) begin
      wr_q.delete(); exp_w.delete();
      a = (t == 0) ? 15'h7FFF : 15'($urandom_range(0, 32767));
      n = (t == 0) ? 2 : $urandom_range(1, 5);
      start();
      send({1'b0, a[14:8]}); send(a[7:0]);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) cyc();
        d = 8'($urandom);
        send(d);
        exp_w.push_back({wrap(int'(a) + i), d});
      end
      cyc(); cyc();
      chk("rw_count", wr_q.size(), exp_w.size());
      for (int i = 0; i < n && i < wr_q.size(); i++) chk("rw_beat", wr_q[i], exp_w[i]);
    end

    // Directed read with prefetch
    rd_q.delete();
    start();
    send(8'h80); send(8'h04);
    chk("rd_first_strobe", {rd_en, rd_addr}, {1'b1, 16'h0004});
    cyc(); cyc();
    respond(8'h5C);
    chk("rd_data", {tx_valid, tx_data}, {1'b1, 8'h5C});
    pulse_ready();
    chk("rd_prefetch", {rd_en, rd_addr, tx_valid}, {1'b1, 16'h0005, 1'b0});

    // Randomized read bursts, one crossing the wrap
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 15'h7FFE : 15'($urandom_range(0, 32767));
      n = $urandom_range(1, 3);
      start();
      send({1'b1, a[14:8]}); send(a[7:0]);
      for (int i = 0; i < n; i++) begin
        chk("rr_strobe", {rd_en, rd_addr}, {1'b1, wrap(int'(a) + i)});
        repeat ($urandom_range(0, 4)) cyc();
        d = 8'($urandom);
        respond(d);
        chk("rr_data", {tx_valid, tx_data}, {1'b1, d});
        repeat ($urandom_range(0, 2)) cyc();
        chk("rr_hold", tx_valid, 1);
        pulse_ready();
      end
      chk("rr_prefetch", {rd_en, rd_addr}, {1'b1, wrap(int'(a) + n)});
      chk("rr_no_status", {underrun, timeout}, 0);
    end

    // Timeout expiry and late response discard
    start();
    send(8'h80); send(8'h10);
    chk("to_strobe", {rd_en, rd_addr}, {1'b1, 16'h0010});
    repeat (254) cyc();
    chk("to_not_yet", {tx_valid, timeout}, 0);
    cyc();
    chk("to_expired", {tx_valid, tx_data, timeout}, {1'b1, 8'hFF, 1'b1});
    respond(8'h33);
    chk("to_late_discard", tx_data, 8'hFF);
    pulse_ready();
    chk("to_next_read", {rd_en, rd_addr, timeout}, {1'b1, 16'h0011, 1'b1});
    start();
    chk("to_cleared", timeout, 0);

    // rd_valid on the expiry cycle wins
    send(8'h80); send(8'h20);
    repeat (254) cyc();
    respond(8'h77);
    chk("tie_data", {tx_valid, tx_data, timeout}, {1'b1, 8'h77, 1'b0});

    // Abort during READ_WAIT, then a stale response
    start();
    send(8'h80); send(8'h40);
    cyc();
    start();
    respond(8'hE1);
    chk("abort_tx_valid", tx_valid, 0);
    wr_q.delete();
    send(8'h12); send(8'h34); send(8'hC3);
    chk("abort_in_addr_hi", {wr_en, wr_addr, wr_data}, {1'b1, 24'h1234C3});

    // txn_start beats a coincident rx byte
    rx_valid = 1'b1; rx_data = 8'hFF;
    start();
    rx_valid = 1'b0;
    send(8'h01); send(8'h02); send(8'h03);
    chk("start_priority", {wr_en, wr_addr, wr_data}, {1'b1, 24'h010203});

    // Underrun leaves the read in flight untouched
    start();
    send(8'h80); send(8'h20);
    rd_q.delete();
    pulse_ready();
    chk("ur_flag", underrun, 1);
    chk("ur_no_strobe", {rd_en, rd_addr}, {1'b0, 16'h0020});
    respond(8'h42);
    chk("ur_data", {tx_valid, tx_data, underrun}, {1'b1, 8'h42, 1'b1});
    cyc(); cyc();
    chk("ur_single_read", rd_q.size(), 1);

    // Reset mid-write aborts immediately
    start();
    chk("ur_cleared", underrun, 0);
    send(8'h12); send(8'h34);
    cyc();
    wr_q.delete();
    rx_valid = 1'b1; rx_data = 8'h55;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {rd_en, wr_en, tx_valid, underrun, timeout}, 0);
    cyc();
    rx_valid = 1'b0;
    chk("rst_mid_buses", {rd_addr, wr_addr, wr_data, tx_data}, 0);
    rst_n = 1'b1;
    send(8'h66); send(8'h77);
    cyc(); cyc();
    chk("rst_no_writes", wr_q.size(), 0);

    chk("never_both_strobes", both_seen, 0);
    chk("addr_bit15_zero", b15_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/management_bridge.md
MANAGEMENT_BRIDGE -- requirements
Module: management_bridge

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, management core clock) and rst_n (input, 1, asynchronous active-low reset); all other ports are synchronous to clk.
REQ-002 The host byte-stream side SHALL have these ports:
- txn_start  input  1  pulse; chip select asserted, new transaction begins
- rx_valid  input  1  pulse; rx_data holds a received host byte
- rx_data  input  8  received byte
- tx_ready  input  1  pulse; host clocks out one read byte
- tx_valid  output  1  tx_data holds the next read byte
- tx_data  output  8  read byte to host
REQ-003 The register bus side SHALL have these ports:
- rd_en  output  1  one-cycle read strobe
- rd_addr  output  16  read address
- rd_valid  input  1  read data valid
- rd_data  input  8  read data
- wr_en  output  1  one-cycle write strobe
- wr_addr  output  16  write address
- wr_data  output  8  write byte
REQ-004 The status side SHALL have these ports:
- underrun  output  1  sticky; host consumed a byte before it was ready
- timeout  output  1  sticky; register bus did not answer a read

REQ-005 The module SHALL have one parameter, RD_TIMEOUT, default 255, giving the number of cycles to wait for rd_valid.

Function
REQ-006 The state machine SHALL have the states IDLE, ADDR_HI, ADDR_LO, WRITE, READ_WAIT and READ_HOLD.
REQ-007 A txn_start pulse in any state SHALL move the block to ADDR_HI, clear tx_valid and abandon any outstanding read.
REQ-008 In ADDR_HI, an rx byte SHALL set cmd_read = byte[7] and addr[14:8] = byte[6:0], then move to ADDR_LO.
REQ-009 In ADDR_LO, an rx byte SHALL set addr[7:0], then move to WRITE if cmd_read = 0, or to READ_WAIT if cmd_read = 1.
REQ-010 On entry to READ_WAIT from ADDR_LO, rd_en SHALL be 1 in the cycle after the address byte, with rd_addr = {1'b0, addr[14:0]}.
REQ-011 Bit 15 of rd_addr and wr_addr SHALL always be 0.
REQ-012 In WRITE, each rx byte SHALL produce wr_en = 1 for exactly one cycle, on the cycle after rx_valid.
REQ-013 For that write, wr_addr SHALL be the current address and wr_data SHALL be the byte.
REQ-014 The address SHALL increment by 1 after each write.
REQ-015 In READ_WAIT, on rd_valid the block SHALL latch rd_data into tx_data, set tx_valid = 1 and move to READ_HOLD.
REQ-016 In READ_HOLD, tx_ready SHALL clear tx_valid, increment the address and issue rd_en for the new address on the next cycle.
REQ-017 After the tx_ready in REQ-016, the block SHALL return to READ_WAIT (prefetch).
REQ-018 Address increment SHALL wrap within 15 bits: 0x7FFF is followed by 0x0000.
REQ-019 In READ_WAIT, a cycle counter SHALL start at rd_en.
REQ-020 If RD_TIMEOUT cycles pass without rd_valid, the block SHALL set tx_data = 0xFF, tx_valid = 1 and timeout = 1, then move to READ_HOLD.
REQ-021 A tx_ready while tx_valid = 0 SHALL set underrun = 1.
REQ-022 In the underrun case of REQ-021, the address SHALL NOT advance and no additional rd_en SHALL be issued.
REQ-023 rx_valid in READ_WAIT, READ_HOLD or IDLE SHALL be ignored.
REQ-024 tx_ready in any state other than READ_WAIT or READ_HOLD SHALL be ignored.
REQ-025 rd_valid in any state other than READ_WAIT SHALL be discarded.
REQ-026 The block SHALL have at most one read outstanding at any time.
REQ-027 rd_en and wr_en SHALL never be asserted in the same cycle.
REQ-028 If txn_start and rx_valid occur in the same cycle, txn_start SHALL take priority and the rx byte SHALL be discarded.
REQ-029 If rd_valid and the timeout expiry occur in the same cycle, rd_valid SHALL win and timeout SHALL NOT be set.
REQ-030 underrun and timeout SHALL clear only on txn_start or on reset.

Reset
REQ-031 While rst_n = 0, the block SHALL be in IDLE.
REQ-032 While rst_n = 0, all outputs SHALL be 0: rd_en, wr_en, tx_valid, underrun, timeout, rd_addr, wr_addr, wr_data and tx_data.
REQ-033 While rst_n = 0, the internal address and the timeout counter SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately and issue no further bus strobes.
REQ-035 After rst_n deasserts, the block SHALL ignore all input until the first txn_start.

Verification
REQ-036 Write burst: txn_start, then bytes 0x12 0x34 0xAA 0xBB -> wr_en twice: (0x1234, 0xAA), then (0x1235, 0xBB); rd_en never asserted.
REQ-037 Read prefetch: txn_start, then bytes 0x80 0x04, with rd_valid returning 0x5C after 3 cycles -> rd_addr = 0x0004, tx_data = 0x5C, tx_valid = 1; after tx_ready, rd_addr = 0x0005 with a fresh rd_en.
REQ-038 Wrap: write starting at address 0x7FFF with two data bytes -> wr_addr 0x7FFF, then 0x0000.
REQ-039 Timeout: read of 0x0010 with rd_valid never asserted -> after 255 cycles tx_data = 0xFF, timeout = 1; a late rd_valid is discarded.
REQ-040 Abort: txn_start during READ_WAIT, followed by rd_valid -> tx_valid stays 0 and the state is ADDR_HI.
REQ-041 Underrun plus reset: tx_ready during READ_WAIT -> underrun = 1 and rd_addr unchanged; then rst_n low mid-write -> all outputs 0 and no wr_en.
